cpu_control: RTL
================

# cpu_control

Multi-cycle sequencer for the mini-CPU: fetches instruction bytes over a req/ack memory handshake, decodes them, and drives the program counter's `en`/`jump`/`jaddr` controls and the ALU strobe. Sits between instruction memory, the `pc` block and the ALU; it owns no PC state itself and only sequences the PC.

## Interface
- `AW`, 8, address/instruction byte width (PC width; `pc_jaddr` width)
- `clk`  in  1  rising-edge clock
- `areset_n`  in  1  asynchronous, active-low reset
- `mem_ack`  in  1  memory has valid `mem_rdata` this cycle
- `mem_rdata`  in  AW  fetched byte
- `alu_zero`  in  1  ALU zero flag, used by JZ
- `resume`  in  1  leave HALT
- `mem_req`  out  1  fetch request, address = current PC
- `pc_en`  out  1  PC enable (increment, or load when `pc_jump`=1)
- `pc_jump`  out  1  PC load select
- `pc_jaddr`  out  AW  jump target
- `alu_en`  out  1  one-cycle ALU execute strobe
- `alu_op`  out  4  ALU operation = IR[3:0]
- `halted`  out  1  controller in HALT
- `illegal`  out  1  sticky, undefined opcode fetched

## Operation
- Opcode = IR[7:4]: 0x0 NOP, 0x1 ALU, 0x8 JMP (2-byte), 0x9 JZ (2-byte), 0xF HLT; all others undefined.
- States: BOOT, FETCH, DECODE, EXEC, FETCH_ADDR, JUMP, HALT.
- BOOT: all outputs 0; next cycle -> FETCH.
- FETCH: `mem_req`=1; on `mem_ack`: IR <= `mem_rdata`, `pc_en`=1 that cycle, -> DECODE; else stay.
- DECODE: NOP -> FETCH; ALU -> EXEC; JMP/JZ -> FETCH_ADDR; HLT -> HALT; undefined -> see Configuration.
- EXEC: `alu_en`=1, -> FETCH.
- FETCH_ADDR: `mem_req`=1; on `mem_ack`: TGT <= `mem_rdata`, `pc_en`=1, -> JUMP.
- JUMP: taken = JMP, or JZ with `alu_zero`=1 sampled this cycle; if taken `pc_en`=1, `pc_jump`=1, `pc_jaddr`=TGT; -> FETCH. Not taken: no PC activity (PC already past address byte).
- HALT: `halted`=1, no requests; `resume`=1 -> FETCH.
- `pc_jaddr` = TGT at all times; `alu_op` = IR[3:0] at all times; `pc_jump` only asserted in JUMP.
- `pc_en` is never asserted except as listed; `mem_req` stays high until acked (no withdrawal).

## Timing
- Reset (`areset_n`=0, any state, mid-handshake included): state BOOT, IR=0, TGT=0, `illegal`=0; all outputs 0 immediately.
- `mem_ack` may arrive the same cycle `mem_req` rises (zero wait); `pc_en` is combinational from `mem_ack` in FETCH/FETCH_ADDR.
- `mem_ack` outside FETCH/FETCH_ADDR is ignored.
- Minimum cycles with zero-wait memory: NOP 2, ALU 3, JMP/JZ 4, HLT 2 then holds. Each memory wait cycle adds 1.
- `resume` asserted outside HALT is ignored; in HALT, FETCH is entered the following cycle.

## Configuration
- `CPU_CTRL_ILLEGAL_TRAP_EN` defined: undefined opcode in DECODE sets `illegal`=1 and -> HALT; `resume` clears neither `illegal` (only reset does) and proceeds to FETCH.
- Not defined: undefined opcode behaves as NOP; `illegal` tied 0.

## Structure
- Package `cpu_ctrl_pkg`: opcode constants (OP_NOP, OP_ALU, OP_JMP, OP_JZ, OP_HLT), state enum, opcode field positions.
- Sub-module `cpu_ctrl_decode`: combinational IR[7:4] -> instruction class (nop/alu/jmp/jz/hlt/undefined); FSM and IR/TGT registers stay in `cpu_control`.

## Test plan
- Reset held 12 ps then released -> one BOOT cycle with all outputs 0, then `mem_req`=1; asserting `areset_n`=0 mid-FETCH drops `mem_req` immediately.
- Fetch 0x00 with `mem_ack` delayed 2 cycles -> `pc_en` single pulse on ack cycle, back to FETCH after DECODE; 4 cycles total.
- Fetch 0x13 -> `alu_en` one cycle with `alu_op`=0x3, total 3 cycles, one `pc_en` pulse.
- Fetch 0x80 then 0x1D -> two `pc_en` pulses, then `pc_en`=`pc_jump`=1 with `pc_jaddr`=0x1D in JUMP.
- Fetch 0x90,0xD0 with `alu_zero`=0 -> no jump pulse, next FETCH; repeat with `alu_zero`=1 -> jump to 0xD0.
- Fetch 0xF0 -> `halted`=1, no `mem_req` for 5 cycles; `resume`=1 -> FETCH next cycle. Fetch 0x50: with macro `illegal`=1 and HALT; without, NOP timing.

Source files
------------

// File: rtl/cpu_control_pkg.sv
// cpu_ctrl_pkg: shared widths, opcode constants, opcode field positions,
// instruction classes and controller state encoding for cpu_control.
package cpu_ctrl_pkg;

   localparam int unsigned AW     = 8;  // address / instruction byte width
   localparam int unsigned OP_MSB = 7;  // opcode field IR[7:4]
   localparam int unsigned OP_LSB = 4;
   localparam int unsigned FN_MSB = 3;  // ALU function field IR[3:0]
   localparam int unsigned FN_LSB = 0;
   localparam int unsigned OPW    = OP_MSB - OP_LSB + 1;
   localparam int unsigned FNW    = FN_MSB - FN_LSB + 1;

   localparam logic [OPW-1:0] OP_NOP = 4'h0;
   localparam logic [OPW-1:0] OP_ALU = 4'h1;
   localparam logic [OPW-1:0] OP_JMP = 4'h8;
   localparam logic [OPW-1:0] OP_JZ  = 4'h9;
   localparam logic [OPW-1:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      CL_NOP,
      CL_ALU,
      CL_JMP,
      CL_JZ,
      CL_HLT,
      CL_UNDEF
   } iclass_e;

   typedef enum logic [2:0] {
      ST_BOOT,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_FETCH_ADDR,
      ST_JUMP,
      ST_HALT
   } state_e;

endpackage

// File: rtl/cpu_control_if.sv
// cpu_control_if: memory handshake, PC controls and ALU strobe of the
// mini-CPU sequencer. master = controller side, slave = memory/PC/ALU side.
interface cpu_control_if;
   import cpu_ctrl_pkg::*;

   logic                 mem_req;
   logic                 mem_ack;
   logic [AW-1:0]        mem_rdata;
   logic                 alu_zero;
   logic                 resume;
   logic                 pc_en;
   logic                 pc_jump;
   logic [AW-1:0]        pc_jaddr;
   logic                 alu_en;
   logic [FNW-1:0]       alu_op;
   logic                 halted;
   logic                 illegal;

   modport master (
      input  mem_ack, mem_rdata, alu_zero, resume,
      output mem_req, pc_en, pc_jump, pc_jaddr, alu_en, alu_op, halted, illegal
   );

   modport slave (
      output mem_ack, mem_rdata, alu_zero, resume,
      input  mem_req, pc_en, pc_jump, pc_jaddr, alu_en, alu_op, halted, illegal
   );

endinterface

// File: rtl/cpu_control_decode.sv
// cpu_ctrl_decode: maps the opcode field IR[7:4] onto an instruction class.
module cpu_ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [OPW-1:0] opcode_i,
   output iclass_e        cls_c_o
);

   // Opcode lookup; anything not listed is undefined.
   always_comb begin
      cls_c_o = CL_UNDEF;
      case (opcode_i)
         OP_NOP:  cls_c_o = CL_NOP;
         OP_ALU:  cls_c_o = CL_ALU;
         OP_JMP:  cls_c_o = CL_JMP;
         OP_JZ:   cls_c_o = CL_JZ;
         OP_HLT:  cls_c_o = CL_HLT;
         default: cls_c_o = CL_UNDEF;
      endcase
   end

endmodule

// File: rtl/cpu_control.sv
// cpu_control: multi-cycle fetch/decode/execute sequencer for the mini-CPU.
// Drives the PC enable/jump controls and the ALU strobe; owns IR and TGT.
// Optional: define CPU_CTRL_ILLEGAL_TRAP_EN to trap undefined opcodes into
// HALT with a sticky illegal flag (otherwise they execute as NOP).
module cpu_control
   import cpu_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 areset_n,
   cpu_control_if.master        bus
);

   state_e        state_q, state_d;
   logic [AW-1:0] ir_q, ir_d;
   logic [AW-1:0] tgt_q, tgt_d;
   iclass_e       cls;
   logic          mem_req_c, pc_en_c, pc_jump_c, alu_en_c, halted_c;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
   logic          illegal_q, illegal_d;
`endif

   cpu_ctrl_decode u_decode (
      .opcode_i (ir_q[OP_MSB:OP_LSB]),
      .cls_c_o  (cls)
   );

   // State, instruction and jump-target registers.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state_q   <= ST_BOOT;
         ir_q      <= '0;
         tgt_q     <= '0;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         tgt_q     <= tgt_d;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   // Next-state and control strobes; pc_en follows mem_ack combinationally.
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      tgt_d     = tgt_q;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      illegal_d = illegal_q;
`endif
      mem_req_c = 1'b0;
      pc_en_c   = 1'b0;
      pc_jump_c = 1'b0;
      alu_en_c  = 1'b0;
      halted_c  = 1'b0;
      case (state_q)
         ST_BOOT: state_d = ST_FETCH;
         ST_FETCH: begin
            mem_req_c = 1'b1;
            if (bus.mem_ack) begin
               ir_d    = bus.mem_rdata;
               pc_en_c = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            case (cls)
               CL_NOP:        state_d = ST_FETCH;
               CL_ALU:        state_d = ST_EXEC;
               CL_JMP, CL_JZ: state_d = ST_FETCH_ADDR;
               CL_HLT:        state_d = ST_HALT;
               CL_UNDEF: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                  illegal_d = 1'b1;
                  state_d   = ST_HALT;
`else
                  state_d   = ST_FETCH;
`endif
               end
               default:       state_d = ST_FETCH;
            endcase
         end
         ST_EXEC: begin
            alu_en_c = 1'b1;
            state_d  = ST_FETCH;
         end
         ST_FETCH_ADDR: begin
            mem_req_c = 1'b1;
            if (bus.mem_ack) begin
               tgt_d   = bus.mem_rdata;
               pc_en_c = 1'b1;
               state_d = ST_JUMP;
            end
         end
         ST_JUMP: begin
            // Not taken: PC already points past the address byte.
            if (cls == CL_JMP || (cls == CL_JZ && bus.alu_zero)) begin
               pc_en_c   = 1'b1;
               pc_jump_c = 1'b1;
            end
            state_d = ST_FETCH;
         end
         ST_HALT: begin
            halted_c = 1'b1;
            if (bus.resume) state_d = ST_FETCH;
         end
         default: state_d = ST_BOOT;
      endcase
   end

   assign bus.mem_req  = mem_req_c;
   assign bus.pc_en    = pc_en_c;
   assign bus.pc_jump  = pc_jump_c;
   assign bus.pc_jaddr = tgt_q;
   assign bus.alu_en   = alu_en_c;
   assign bus.alu_op   = ir_q[FN_MSB:FN_LSB];
   assign bus.halted   = halted_c;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
   assign bus.illegal  = illegal_q;
`else
   assign bus.illegal  = 1'b0;
`endif

endmodule
